// File: rtl/sdram_req_queue.sv
// sdram_req_queue: host-side request buffer in front of the SDRAM controller.
// Requests are queued in a small FIFO. One request at a time is presented to
// the controller as a level-held enable until the controller reports busy.
// Read data comes back as a single-cycle response pulse.
module sdram_req_queue #(
    parameter int HADDR_WIDTH = 25,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // host request channel
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    // host response channel
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   queue_idle,
    // controller interface
    output logic                   sdr_wr_enable,
    output logic                   sdr_rd_enable,
    output logic [HADDR_WIDTH-1:0] sdr_wr_addr,
    output logic [HADDR_WIDTH-1:0] sdr_rd_addr,
    output logic [DATA_WIDTH-1:0]  sdr_wr_data,
    input  logic                   sdr_busy,
    input  logic                   sdr_rd_ready,
    input  logic [DATA_WIDTH-1:0]  sdr_rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    typedef struct packed {
        logic                   we;
        logic [HADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]  wdata;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_WR,
        WAIT_RD
    } state_t;

    entry_t               fifo_mem [DEPTH];
    logic [DEPTH_LOG2:0]  wr_ptr;
    logic [DEPTH_LOG2:0]  rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    entry_t               head;
    state_t               state;
    logic                 hold_we;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // Readiness depends only on stored state, never on req_valid.
    assign req_ready  = !full;
    assign push       = req_valid && !full;
    // A new request is only taken once the controller has gone quiet, which
    // also covers busy lagging rd_ready by a cycle after a read.
    assign pop        = (state == IDLE) && !empty && !sdr_busy;
    assign head       = fifo_mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign queue_idle = empty && (state == IDLE);

    // Request storage: written on push, read at the head pointer.
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only add reset fanout.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[DEPTH_LOG2-1:0]] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        end
    end

    // FIFO pointers; simultaneous push and pop both advance, count unchanged.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Issue FSM with registered controller-side and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_we       <= 1'b0;
            sdr_wr_enable <= 1'b0;
            sdr_rd_enable <= 1'b0;
            sdr_wr_addr   <= '0;
            sdr_rd_addr   <= '0;
            sdr_wr_data   <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        hold_we <= head.we;
                        // Only the active direction's address is updated; the
                        // other side keeps its previous value.
                        if (head.we) begin
                            sdr_wr_addr   <= head.addr;
                            sdr_wr_data   <= head.wdata;
                            sdr_wr_enable <= 1'b1;
                        end else begin
                            sdr_rd_addr   <= head.addr;
                            sdr_rd_enable <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Enable is a level: the controller may be refreshing and
                    // ignore it for a while, so hold until busy is seen.
                    if (sdr_busy) begin
                        sdr_wr_enable <= 1'b0;
                        sdr_rd_enable <= 1'b0;
                        state         <= hold_we ? WAIT_WR : WAIT_RD;
                    end
                end
                WAIT_WR: begin
                    if (!sdr_busy) state <= IDLE;
                end
                WAIT_RD: begin
                    if (sdr_rd_ready) begin
                        rsp_rdata <= sdr_rd_data;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue with a behavioural SDRAM controller
// model (refresh stall, busy stall, read latency, byte memory).
module tb_sdram_req_queue;

    localparam int AW = 25;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          queue_idle;
    logic          sdr_wr_enable;
    logic          sdr_rd_enable;
    logic [AW-1:0] sdr_wr_addr;
    logic [AW-1:0] sdr_rd_addr;
    logic [DW-1:0] sdr_wr_data;
    logic          sdr_busy = 1'b0;
    logic          sdr_rd_ready = 1'b0;
    logic [DW-1:0] sdr_rd_data = '0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    op_t           op_q [$];
    logic [DW-1:0] rsp_q [$];
    logic [DW-1:0] mem_m [logic [AW-1:0]];

    int            m_ignore = 0;
    int            m_rd_lat = 4;
    bit            m_stall = 1'b0;
    int            m_viol = 0;
    int            m_en_cycles = 0;
    int            m_state = 0;
    int            m_cnt = 0;
    int            m_ign = 0;
    op_t           m_cur = '0;
    logic [AW-1:0] m_seen_addr = '0;
    bit            prev_rsp = 1'b0;

    sdram_req_queue #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .queue_idle    (queue_idle),
        .sdr_wr_enable (sdr_wr_enable),
        .sdr_rd_enable (sdr_rd_enable),
        .sdr_wr_addr   (sdr_wr_addr),
        .sdr_rd_addr   (sdr_rd_addr),
        .sdr_wr_data   (sdr_wr_data),
        .sdr_busy      (sdr_busy),
        .sdr_rd_ready  (sdr_rd_ready),
        .sdr_rd_data   (sdr_rd_data)
    );

    always #5 clk = ~clk;

    // Controller model and response monitor, both working on the falling edge.
    always @(negedge clk) begin : ctrl_model
        logic [AW-1:0] a;
        if (!rst_n) begin
            m_state      = 0;
            m_ign        = 0;
            sdr_busy     = 1'b0;
            sdr_rd_ready = 1'b0;
        end else begin
            if (sdr_wr_enable || sdr_rd_enable) m_en_cycles++;
            if (sdr_wr_enable && sdr_rd_enable) m_viol++;
            if (m_state == 0) begin
                if (sdr_wr_enable || sdr_rd_enable) begin
                    a = sdr_wr_enable ? sdr_wr_addr : sdr_rd_addr;
                    if (m_ign == 0) m_seen_addr = a;
                    else if (a != m_seen_addr) m_viol++;
                    if (m_ign < m_ignore) begin
                        m_ign++;
                    end else begin
                        m_ign = 0;
                        m_cur = '{we: sdr_wr_enable, addr: a, data: sdr_wr_data};
                        op_q.push_back(m_cur);
                        if (m_cur.we) mem_m[a] = sdr_wr_data;
                        sdr_busy = 1'b1;
                        m_cnt    = 0;
                        m_state  = 1;
                    end
                end
            end else begin
                if (sdr_wr_enable || sdr_rd_enable) m_viol++;
                m_cnt++;
                sdr_rd_ready = 1'b0;
                if (!m_cur.we && m_cnt == m_rd_lat) begin
                    sdr_rd_ready = 1'b1;
                    sdr_rd_data  = mem_m.exists(m_cur.addr) ? mem_m[m_cur.addr] : 8'h00;
                end
                // busy drops one cycle after rd_ready for reads
                if (m_cnt >= (m_cur.we ? 3 : m_rd_lat + 2) && !m_stall) begin
                    sdr_busy = 1'b0;
                    m_state  = 0;
                end
            end
        end
        if (rsp_valid) begin
            rsp_q.push_back(rsp_rdata);
            if (prev_rsp) m_viol++;
        end
        prev_rsp = rsp_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request starting at a falling edge; returns on the falling
    // edge after the accepting rising edge with req_valid low.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept_timeout", 32'(n < 200), 32'(1));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(queue_idle === 1'b1 && sdr_busy === 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(queue_idle), 32'(1));
        @(negedge clk);
    endtask

    initial begin : stim
        int ob;
        int rb;
        mem_m[25'h1ABCDEF] = 8'h3C;

        // ---- reset values ----
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_queue_idle", 32'(queue_idle), 32'(1));
        check("rst_wr_en", 32'(sdr_wr_enable), 32'(0));
        check("rst_rd_en", 32'(sdr_rd_enable), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_wr_addr", 32'(sdr_wr_addr), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- single write ----
        ob = op_q.size();
        m_en_cycles = 0;
        send(1'b1, 25'h0000123, 8'hA5);
        check("w1_en_not_yet", 32'(sdr_wr_enable), 32'(0));
        check("w1_idle_low", 32'(queue_idle), 32'(0));
        @(negedge clk);
        check("w1_en_high", 32'(sdr_wr_enable), 32'(1));
        check("w1_rd_en_low", 32'(sdr_rd_enable), 32'(0));
        check("w1_addr", 32'(sdr_wr_addr), 32'h123);
        check("w1_data", 32'(sdr_wr_data), 32'hA5);
        @(negedge clk);
        check("w1_en_dropped", 32'(sdr_wr_enable), 32'(0));
        wait_idle("w1_idle_timeout");
        check("w1_op_count", 32'(op_q.size() - ob), 32'(1));
        check("w1_op_addr", 32'(op_q[ob].addr), 32'h123);
        check("w1_op_data", 32'(op_q[ob].data), 32'hA5);
        check("w1_en_cycles", 32'(m_en_cycles), 32'(1));

        // ---- read with latency 4, followed by a write ----
        ob = op_q.size();
        rb = rsp_q.size();
        send(1'b0, 25'h1ABCDEF, 8'h00);
        send(1'b1, 25'h0000040, 8'h77);
        wait_idle("r1_idle_timeout");
        check("r1_rsp_count", 32'(rsp_q.size() - rb), 32'(1));
        check("r1_rsp_data", 32'(rsp_q[rb]), 32'h3C);
        check("r1_rsp_rdata_port", 32'(rsp_rdata), 32'h3C);
        check("r1_op0_read", 32'(op_q[ob].we), 32'(0));
        check("r1_op0_addr", 32'(op_q[ob].addr), 32'h1ABCDEF);
        check("r1_op1_addr", 32'(op_q[ob + 1].addr), 32'h40);
        check("r1_rd_addr_held", 32'(sdr_rd_addr), 32'h1ABCDEF);
        check("r1_viol", 32'(m_viol), 32'(0));

        // ---- refresh collision: enable ignored for 20 cycles ----
        ob = op_q.size();
        m_ignore = 20;
        m_en_cycles = 0;
        send(1'b1, 25'h0000077, 8'h5A);
        wait_idle("ref_idle_timeout");
        m_ignore = 0;
        check("ref_en_cycles", 32'(m_en_cycles), 32'(21));
        check("ref_op_count", 32'(op_q.size() - ob), 32'(1));
        check("ref_op_addr", 32'(op_q[ob].addr), 32'h77);
        check("ref_viol", 32'(m_viol), 32'(0));

        // ---- fill with controller stalled ----
        ob = op_q.size();
        m_stall = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b1, AW'(32'h100 + i), DW'(8'h60 + i));
        check("fill_ready_low", 32'(req_ready), 32'(0));
        check("fill_one_issued", 32'(op_q.size() - ob), 32'(1));
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 25'h00001FF;
        req_wdata = 8'hEE;
        repeat (3) @(negedge clk);
        check("fill_ready_still_low", 32'(req_ready), 32'(0));
        req_valid = 1'b0;
        m_stall = 1'b0;
        wait_idle("fill_idle_timeout");
        check("fill_op_count", 32'(op_q.size() - ob), 32'(5));
        for (int i = 0; i < 5; i++) begin
            check("fill_order_addr", 32'(op_q[ob + i].addr), 32'h100 + i);
            check("fill_order_data", 32'(op_q[ob + i].data), 32'h60 + i);
        end

        // ---- mixed traffic against memory model, then pointer wrap ----
        rb = rsp_q.size();
        send(1'b1, 25'h10, 8'h11);
        send(1'b0, 25'h10, 8'h00);
        send(1'b1, 25'h20, 8'h22);
        send(1'b0, 25'h20, 8'h00);
        wait_idle("mix_idle_timeout");
        check("mix_rsp_count", 32'(rsp_q.size() - rb), 32'(2));
        check("mix_rsp0", 32'(rsp_q[rb]), 32'h11);
        check("mix_rsp1", 32'(rsp_q[rb + 1]), 32'h22);
        rb = rsp_q.size();
        for (int i = 0; i < 6; i++) begin
            send(1'b1, AW'(32'h30 + i), DW'(8'h90 + i));
            send(1'b0, AW'(32'h30 + i), 8'h00);
        end
        wait_idle("wrap_idle_timeout");
        check("wrap_rsp_count", 32'(rsp_q.size() - rb), 32'(6));
        for (int i = 0; i < 6; i++) check("wrap_rsp", 32'(rsp_q[rb + i]), 32'h90 + i);
        check("mix_viol", 32'(m_viol), 32'(0));

        // ---- async reset while in WAIT_RD with two queued ----
        m_rd_lat = 30;
        send(1'b0, 25'h20, 8'h00);
        send(1'b1, 25'h50, 8'h01);
        send(1'b1, 25'h51, 8'h02);
        ob = op_q.size();
        rb = rsp_q.size();
        check("mid_busy", 32'(sdr_busy), 32'(1));
        check("mid_rd_en_low", 32'(sdr_rd_enable), 32'(0));
        check("mid_not_idle", 32'(queue_idle), 32'(0));
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'(1));
        check("arst_queue_idle", 32'(queue_idle), 32'(1));
        check("arst_rd_addr", 32'(sdr_rd_addr), 32'(0));
        check("arst_wr_addr", 32'(sdr_wr_addr), 32'(0));
        check("arst_wr_data", 32'(sdr_wr_data), 32'(0));
        check("arst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("arst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("arst_enables", 32'({sdr_wr_enable, sdr_rd_enable}), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_rd_lat = 4;
        repeat (40) @(negedge clk);
        check("post_rst_no_rsp", 32'(rsp_q.size() - rb), 32'(0));
        check("post_rst_no_issue", 32'(op_q.size() - ob), 32'(0));
        check("post_rst_ready", 32'(req_ready), 32'(1));
        check("post_rst_idle", 32'(queue_idle), 32'(1));
        check("final_viol", 32'(m_viol), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_req_queue.md
Name: sdram_req_queue

Overview:
- Host-side request stage directly upstream of the SDRAM controller.
- Accepts read/write requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the controller's single-cycle-sampled wr_enable/rd_enable/busy interface, holding each request until the controller acknowledges it.
- Returns read data as a one-cycle response pulse.

Parameters:
- HADDR_WIDTH, 25, host byte address width (bank+row+col), matches controller.
- DATA_WIDTH, 8, data width, matches controller.
- DEPTH_LOG2, 2, log2 of request FIFO depth (default 4 entries).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  queue can accept; transfer when req_valid & req_ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  HADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse, rsp_rdata valid.
- rsp_rdata  out  DATA_WIDTH  read data.
- queue_idle  out  1  FIFO empty and FSM in IDLE.
- sdr_wr_enable  out  1  to controller wr_enable.
- sdr_rd_enable  out  1  to controller rd_enable.
- sdr_wr_addr  out  HADDR_WIDTH  to controller wr_addr.
- sdr_rd_addr  out  HADDR_WIDTH  to controller rd_addr.
- sdr_wr_data  out  DATA_WIDTH  to controller wr_data.
- sdr_busy  in  1  controller busy (high during read/write sequences).
- sdr_rd_ready  in  1  controller read-data-valid pulse.
- sdr_rd_data  in  DATA_WIDTH  controller read data.

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty; FSM=IDLE.
  - sdr_wr_enable=sdr_rd_enable=0; sdr addresses and data=0.
  - rsp_valid=0, rsp_rdata=0; req_ready=1; queue_idle=1.
- Reset mid-operation discards all queued and in-flight requests; no rsp_valid for them.
- FIFO:
  - 2^DEPTH_LOG2 entries of {we, addr, wdata}.
  - Read/write pointers are DEPTH_LOG2+1 bits, so full/empty is distinguished by the MSB; pointers wrap modulo 2^(DEPTH_LOG2+1).
  - req_ready = !full (registered-state derived, no combinational path from req_valid).
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push when full cannot occur, because req_ready=0.
- FSM states:
  - IDLE:
    - If FIFO non-empty and sdr_busy==0: pop the head into the hold register.
    - Drive sdr_*_addr and sdr_wr_data from the popped entry.
    - Assert sdr_wr_enable (we=1) or sdr_rd_enable (we=0) from the next cycle.
    - Go to ISSUE.
    - If sdr_busy==1, wait.
  - ISSUE:
    - Hold the enable, address and data stable until sdr_busy==1 is sampled.
    - The enable is a level, not a pulse: the controller may be in refresh and ignore it for many cycles.
    - On sdr_busy==1: deassert the enable that same edge.
    - Write goes to WAIT_WR; read goes to WAIT_RD.
  - WAIT_WR: on sdr_busy==0, go to IDLE.
  - WAIT_RD:
    - On sdr_rd_ready==1: capture sdr_rd_data into rsp_rdata, pulse rsp_valid for exactly 1 cycle, go to IDLE.
    - IDLE's busy==0 check prevents reissuing while the controller's busy lags rd_ready by one cycle.
- Only one of sdr_wr_enable/sdr_rd_enable is ever high. Both are 0 outside ISSUE.
- Addresses for the unused direction hold their previous value.
- Ordering: strict FIFO order; at most one request in flight; responses are in read-request order.
- Minimum issue gap: back-to-back requests are separated by at least one IDLE cycle with sdr_busy==0.
- queue_idle = empty & (state==IDLE).
- No timeout; a controller that never asserts busy stalls the queue (covered by bench assertion, not RTL).

Test Plan:
- Reset, then write addr 0x0000123 data 0xA5 with a controller model: sdr_wr_enable rises the cycle after acceptance, holds until busy=1, drops the same edge; addr 0x0000123 and data 0xA5 stable throughout; queue_idle returns to 1 after busy falls.
- Read addr 0x1ABCDEF, model returns 0x3C with rd_ready 4 cycles after busy rises: exactly one rsp_valid cycle with rsp_rdata=0x3C; no second issue until busy=0.
- Refresh collision: model holds busy=0 for 20 cycles after enable asserts, then accepts. Required: enable held high all 20 cycles with constant address, single controller operation.
- Fill: push 5 requests back-to-back with the controller stalled (busy stuck high). Required: first popped, next 4 fill FIFO, req_ready=0 after 4th queued, 6th not accepted; on release all 5 execute in order.
- Mixed W(0x10,0x11), R(0x10), W(0x20,0x22), R(0x20) against a memory model: rsp_rdata 0x11 then 0x22, in order; pointer wrap exercised by 12 further requests.
- Assert rst_n low while in WAIT_RD with 2 queued: all outputs go to reset values asynchronously; no rsp_valid afterwards; req_ready=1, queue_idle=1.
